// File: rtl/lu_arbiter_pkg.sv
// Shared types and helpers for the round-robin logic-unit arbiter.
package lu_arbiter_pkg;

  typedef enum logic [1:0] {
    LU_AND  = 2'b00,
    LU_OR   = 2'b01,
    LU_XOR  = 2'b10,
    LU_NAND = 2'b11
  } lu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_e;

  localparam int STAT_W = 16;

  // One bit of the shared logic unit. Callers loop over the data width,
  // which keeps the function independent of DATA_W.
  function automatic logic lu_compute(lu_op_e op, logic a, logic b);
    logic r;
    unique case (op)
      LU_AND:  r = a & b;
      LU_OR:   r = a | b;
      LU_XOR:  r = a ^ b;
      LU_NAND: r = ~(a & b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lu_arbiter_rr.sv
// Combinational round-robin search. The winner is the first set request
// found starting at ptr and wrapping; grants are suppressed when en is low.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any_gnt
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Search from the pointer, first hit wins.
  always_comb begin
    found   = 1'b0;
    idx     = '0;
    gnt_idx = '0;
    gnt     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    any_gnt = found && en;
    if (any_gnt) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/lu_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between N_REQ clients,
// with a single-entry registered result stage.
// Optional per-requester grant counters: define LU_ARBITER_STATS_EN.
//
// Output stage states:
//   state    | meaning
//   ST_EMPTY | no result held, rsp_valid_o low, any winner may transfer
//   ST_FULL  | result held; new transfer only if consumer takes it this cycle
module lu_arbiter
  import lu_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*DATA_W-1:0] req_a_i,
  input  logic [N_REQ*DATA_W-1:0] req_b_i,
  input  logic [N_REQ*2-1:0]      req_op_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [DATA_W-1:0]       rsp_data_o
`ifdef LU_ARBITER_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] grant_cnt_o
`endif
);

  stage_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              any_gnt;
  logic              can_accept;
  logic [DATA_W-1:0] op_a, op_b, result;
  lu_op_e            op_sel;

  // A slot frees up in the same cycle the consumer takes the held result.
  assign can_accept = (state_q == ST_EMPTY) || rsp_ready_i;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req     (req_valid_i),
    .ptr     (ptr_q),
    .en      (can_accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign req_ready_o = gnt;
  assign op_a        = req_a_i[gnt_idx*DATA_W +: DATA_W];
  assign op_b        = req_b_i[gnt_idx*DATA_W +: DATA_W];
  assign op_sel      = lu_op_e'(req_op_i[gnt_idx*2 +: 2]);

  // Shared logic unit on the winner's operands.
  always_comb begin
    result = '0;
    for (int i = 0; i < DATA_W; i++) begin
      result[i] = lu_compute(op_sel, op_a[i], op_b[i]);
    end
  end

  // Output stage next state; a transfer always wins over a drain.
  always_comb begin
    state_d = state_q;
    if (any_gnt) begin
      state_d = ST_FULL;
    end else if (rsp_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  // Output stage state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Capture result and rotate the pointer past the winner on each transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_id_o   <= '0;
      rsp_data_o <= '0;
      ptr_q      <= '0;
    end else if (any_gnt) begin
      rsp_id_o   <= gnt_idx;
      rsp_data_o <= result;
      if (gnt_idx == ID_W'(N_REQ - 1)) ptr_q <= '0;
      else                             ptr_q <= gnt_idx + 1'b1;
    end
  end

  assign rsp_valid_o = (state_q == ST_FULL);

`ifdef LU_ARBITER_STATS_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    logic [STAT_W-1:0] cnt_q;

    // Saturating count of transfers from requester g.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else if (gnt[g] && (cnt_q != {STAT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign grant_cnt_o[g*STAT_W +: STAT_W] = cnt_q;
  end
`endif

endmodule

// File: doc/lu_arbiter.md
Name: lu_arbiter

Overview:
- Round-robin arbiter that shares one bitwise logic unit (AND/OR/XOR/NAND) between N_REQ requesters.
- Each requester presents two operands and an opcode on a valid/ready handshake.
- The block grants one requester per cycle, computes the result and registers it into a single-entry output stage with requester ID and backpressure.
- Sits between multiple client blocks and the shared gate-level datapath.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 8, operand/result width in bits; all operations are bitwise over the full width.
- ID_W, $clog2(N_REQ), width of the requester ID; derived, not overridden.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_ready_o  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_a_i  in  N_REQ*DATA_W  operand A; requester i at [i*DATA_W +: DATA_W].
- req_b_i  in  N_REQ*DATA_W  operand B; same slicing.
- req_op_i  in  N_REQ*2  opcode; requester i at [i*2 +: 2].
- rsp_valid_o  out  1  result valid.
- rsp_ready_i  in  1  consumer accepts result.
- rsp_id_o  out  ID_W  index of the requester that produced the result.
- rsp_data_o  out  DATA_W  result.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rr pointer=0.
  - req_ready_o is combinational and therefore 0 when rsp_valid_o=0 and no valid is present.
- Opcodes:
  - 00 AND (a & b), 01 OR (a | b), 10 XOR (a ^ b), 11 NAND (~(a & b)).
  - Bitwise over DATA_W; no logical (&&) reduction.
- Output stage has two states:
  - EMPTY (rsp_valid_o=0).
  - FULL (rsp_valid_o=1).
- Stage may accept when: can_accept = EMPTY, or (FULL and rsp_ready_i).
- Grant:
  - Combinational round-robin search over req_valid_i, starting at the pointer and wrapping from N_REQ-1 to 0.
  - req_ready_o[g]=1 only for the winner g, and only when can_accept.
- Transfer:
  - A request transfers in cycle T when req_valid_i[g] and req_ready_o[g] are both high.
  - In T+1: rsp_valid_o=1, rsp_id_o=g, rsp_data_o=op(a_g,b_g). Latency is 1 cycle.
- Pointer update: on transfer, pointer <= (g+1) mod N_REQ. With no transfer, the pointer holds.
- Stage transitions:
  - Output accept (FULL with rsp_ready_i) and no new transfer: FULL->EMPTY.
  - Simultaneous output accept and new transfer: stays FULL with the new data. Full throughput is 1 result/cycle.
  - FULL with rsp_ready_i=0: rsp_id_o and rsp_data_o hold stable; all req_ready_o=0.
- Requester rules:
  - A requester keeps valid and payload stable until ready.
  - The arbiter never revokes a grant within a cycle.
- Fairness: with all requesters continuously valid and rsp_ready_i=1, grants cycle 0,1,2,3,0,… Any valid requester waits at most N_REQ-1 transfers.
- Reset mid-operation: a pending result is discarded, rsp_valid_o drops immediately, and the pointer returns to 0.
- A single valid requester is granted every cycle the stage can accept, with no bubble.

Optional Feature:
- Macro: LU_ARBITER_STATS_EN.
- Defined:
  - Adds output port grant_cnt_o, width N_REQ*16: one 16-bit counter per requester at [i*16 +: 16].
  - Counter i increments on each transfer from requester i.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package lu_arbiter_pkg:
  - lu_op_e enum (LU_AND=2'b00, LU_OR=2'b01, LU_XOR=2'b10, LU_NAND=2'b11).
  - Function lu_compute(op, a, b).
  - Constant STAT_W=16.
- Sub-module rr_arbiter:
  - Parameterised on N_REQ.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, grant index, any_grant.
  - The pointer register lives in lu_arbiter.

Test Plan:
- Reset: assert rst_i mid-FULL with rsp_data_o=8'hA5 -> rsp_valid_o=0 and rsp_data_o=0 immediately; after release, first grant goes to requester 0 when all valid.
- Ops: requester 2 with a=8'hF0, b=8'h3C for op 00/01/10/11 -> rsp_data_o 8'h30 / 8'hFC / 8'hCC / 8'hCF, rsp_id_o=2, each 1 cycle after handshake.
- Fairness: all 4 valid continuously, rsp_ready_i=1 for 8 cycles -> rsp_id_o sequence 0,1,2,3,0,1,2,3; one-hot req_ready_o every cycle.
- Backpressure: rsp_ready_i=0 for 5 cycles while FULL -> outputs stable, req_ready_o=0. Raise rsp_ready_i -> same-cycle new grant, next result the following cycle.
- Wrap/skip: pointer=3, only requesters 1 and 3 valid -> grant 3 then 1. Pointer ends at 2.
- Stats (LU_ARBITER_STATS_EN): force 65537 grants to requester 0 -> grant_cnt_o[15:0]=16'hFFFF, other counters unchanged.
